// File: rtl/board_access_ctrl.sv
// Minesweeper board RAM owner: muxes the single RAM port between VGA reads and
// blanking-time reveal/flag read-modify-writes, and moves the cursor per frame.
module board_access_ctrl #(
  parameter int GRID_W = 5,
  parameter int GRID_H = 5,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              screen_end,
  input  logic              left,
  input  logic              right,
  input  logic              up,
  input  logic              down,
  input  logic              select,
  input  logic              flag,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wen,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [2:0]        cursor_x,
  output logic [2:0]        cursor_y,
  output logic              busy,
  output logic              done,
  output logic              mine_hit
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_DONE} state_t;

  localparam int B_L = 0, B_R = 1, B_U = 2, B_D = 3, B_S = 4, B_F = 5;

  state_t            state_q, state_d;
  logic [5:0]        btn, btn_q, btn_edge, pend_q, pend_d, clr;
  logic              se_q, tick;
  logic [2:0]        cursor_x_q, cursor_x_d, cursor_y_q, cursor_y_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic              op_flag_q, op_flag_d;
  logic              mine_q, mine_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [DATA_W-1:0] vga_hold_q, vga_hold_d;
  logic [3:0]        rd_status, rd_contents;

  assign btn         = {flag, select, down, up, right, left};
  assign btn_edge    = btn & ~btn_q;
  assign tick        = screen_end & ~se_q;
  assign rd_status   = ram_dout[3:0];
  assign rd_contents = ram_dout[7:4];

  always_comb begin
    state_d    = state_q;
    cursor_x_d = cursor_x_q;
    cursor_y_d = cursor_y_q;
    target_d   = target_q;
    op_flag_d  = op_flag_q;
    mine_d     = mine_q;
    word_d     = word_q;
    clr        = '0;

    if (tick) begin
      clr[3:0] = 4'hF;
      // Opposing presses in one frame cancel; edges of the grid clamp.
      if (pend_q[B_R] && !pend_q[B_L] && cursor_x_q != 3'(GRID_W - 1))
        cursor_x_d = cursor_x_q + 3'd1;
      else if (pend_q[B_L] && !pend_q[B_R] && cursor_x_q != 3'd0)
        cursor_x_d = cursor_x_q - 3'd1;
      if (pend_q[B_D] && !pend_q[B_U] && cursor_y_q != 3'(GRID_H - 1))
        cursor_y_d = cursor_y_q + 3'd1;
      else if (pend_q[B_U] && !pend_q[B_D] && cursor_y_q != 3'd0)
        cursor_y_d = cursor_y_q - 3'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (tick && (pend_q[B_S] || pend_q[B_F])) begin
          target_d  = ADDR_W'(cursor_y_q) * ADDR_W'(GRID_W) + ADDR_W'(cursor_x_q);
          op_flag_d = !pend_q[B_S];
          clr[B_S]  = pend_q[B_S];
          clr[B_F]  = !pend_q[B_S];
          state_d   = S_RD;
        end
      end
      S_RD: state_d = S_CAP;
      S_CAP: begin
        mine_d  = 1'b0;
        state_d = S_DONE;
        if (!op_flag_q) begin
          if (rd_status == 4'd10) begin
            word_d  = {ram_dout[DATA_W-1:4], rd_contents};
            mine_d  = (rd_contents == 4'd9);
            state_d = S_WR;
          end
        end else if (rd_status == 4'd10) begin
          word_d  = {ram_dout[DATA_W-1:4], 4'd11};
          state_d = S_WR;
        end else if (rd_status == 4'd11) begin
          word_d  = {ram_dout[DATA_W-1:4], 4'd10};
          state_d = S_WR;
        end
      end
      S_WR:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    pend_d = (pend_q & ~clr) | btn_edge;
  end

  assign vga_hold_d = (state_q == S_IDLE) ? ram_dout : vga_hold_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      btn_q      <= '0;
      pend_q     <= '0;
      se_q       <= 1'b0;
      cursor_x_q <= '0;
      cursor_y_q <= '0;
      target_q   <= '0;
      op_flag_q  <= 1'b0;
      mine_q     <= 1'b0;
      word_q     <= '0;
      vga_hold_q <= '0;
    end else begin
      state_q    <= state_d;
      btn_q      <= btn;
      pend_q     <= pend_d;
      se_q       <= screen_end;
      cursor_x_q <= cursor_x_d;
      cursor_y_q <= cursor_y_d;
      target_q   <= target_d;
      op_flag_q  <= op_flag_d;
      mine_q     <= mine_d;
      word_q     <= word_d;
      vga_hold_q <= vga_hold_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign ram_addr = busy ? target_q : vga_addr;
  assign ram_wen  = (state_q == S_WR);
  assign ram_din  = word_q;
  assign vga_data = busy ? vga_hold_q : ram_dout;
  assign done     = (state_q == S_DONE);
  assign mine_hit = done & mine_q;
  assign cursor_x = cursor_x_q;
  assign cursor_y = cursor_y_q;

endmodule

// File: tb/tb_board_access_ctrl.sv
// Directed bench for board_access_ctrl with a synchronous-read RAM model.
module tb_board_access_ctrl;

  logic        clk;
  logic        reset;
  logic        screen_end;
  logic [5:0]  btn;  // {flag, select, down, up, right, left}
  logic [9:0]  vga_addr;
  logic [31:0] vga_data;
  logic [9:0]  ram_addr;
  logic        ram_wen;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic [2:0]  cursor_x, cursor_y;
  logic        busy, done, mine_hit;

  logic [31:0] mem [0:31];
  logic        pl_en;
  logic [4:0]  pl_addr;
  logic [31:0] pl_dat;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [5:0] L = 6'b000001, R = 6'b000010, U = 6'b000100,
                         D = 6'b001000, S = 6'b010000, F = 6'b100000;

  board_access_ctrl dut (
    .clk(clk), .reset(reset), .screen_end(screen_end),
    .left(btn[0]), .right(btn[1]), .up(btn[2]), .down(btn[3]),
    .select(btn[4]), .flag(btn[5]),
    .vga_addr(vga_addr), .vga_data(vga_data),
    .ram_addr(ram_addr), .ram_wen(ram_wen), .ram_din(ram_din), .ram_dout(ram_dout),
    .cursor_x(cursor_x), .cursor_y(cursor_y),
    .busy(busy), .done(done), .mine_hit(mine_hit)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_dat;
    else if (ram_wen) mem[ram_addr[4:0]] <= ram_din;
    ram_dout <= mem[ram_addr[4:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_dat = d;
    cyc(1);
    pl_en = 1'b0;
  endtask

  task automatic press(input logic [5:0] b);
    btn = b;
    cyc(1);
    btn = '0;
    cyc(1);
  endtask

  // Returns at the sample point of T+1.
  task automatic tick_start();
    screen_end = 1'b1;
    cyc(1);
    screen_end = 1'b0;
  endtask

  task automatic move(input logic [5:0] b, input string tag,
                      input logic [2:0] ex, input logic [2:0] ey);
    press(b);
    tick_start();
    chk({tag, "_x"}, 32'(cursor_x), 32'(ex));
    chk({tag, "_y"}, 32'(cursor_y), 32'(ey));
    cyc(2);
  endtask

  initial begin
    reset = 1'b0; screen_end = 1'b0; btn = '0; vga_addr = '0;
    pl_en = 1'b0; pl_addr = '0; pl_dat = '0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0000_000A;
    cyc(2);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wen", 32'(ram_wen), 32'd0);
    chk("rst_cx", 32'(cursor_x), 32'd0);
    chk("rst_cy", 32'(cursor_y), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b1;
    cyc(2);

    // VGA pass-through while idle
    preload(5'd7, 32'h0000_003A);
    vga_addr = 10'd7;
    #1 chk("vga_addr", 32'(ram_addr), 32'd7);
    cyc(2);
    chk("vga_data", vga_data, 32'h0000_003A);

    // Cursor moves with clamping
    for (int i = 0; i < 6; i++)
      move(R, "right", (i < 4) ? 3'(i + 1) : 3'd4, 3'd0);
    btn = D;
    cyc(1);
    tick_start();
    cyc(2);
    tick_start();
    chk("held_down_y", 32'(cursor_y), 32'd1);
    btn = '0;
    cyc(2);
    move(L | R, "lr_cancel", 3'd4, 3'd1);
    move(L, "left1", 3'd3, 3'd1);
    move(L, "left2", 3'd2, 3'd1);

    // Reveal cell 7: 0x3A -> 0x33
    press(S);
    tick_start();
    chk("rv7_t1_addr", 32'(ram_addr), 32'd7);
    chk("rv7_t1_wen", 32'(ram_wen), 32'd0);
    chk("rv7_t1_busy", 32'(busy), 32'd1);
    cyc(1);
    chk("rv7_t2_wen", 32'(ram_wen), 32'd0);
    cyc(1);
    chk("rv7_t3_wen", 32'(ram_wen), 32'd1);
    chk("rv7_t3_din", ram_din, 32'h0000_0033);
    chk("rv7_t3_addr", 32'(ram_addr), 32'd7);
    cyc(1);
    chk("rv7_t4_done", 32'(done), 32'd1);
    chk("rv7_t4_mine", 32'(mine_hit), 32'd0);
    cyc(1);
    chk("rv7_t5_busy", 32'(busy), 32'd0);
    chk("rv7_t5_done", 32'(done), 32'd0);
    cyc(1);

    // Reveal a mine at cell 0
    move(U | L, "upleft", 3'd1, 3'd0);
    move(L, "left3", 3'd0, 3'd0);
    preload(5'd0, 32'h0000_009A);
    press(S);
    tick_start();
    cyc(2);
    chk("mine_t3_wen", 32'(ram_wen), 32'd1);
    chk("mine_t3_din", ram_din, 32'h0000_0099);
    cyc(1);
    chk("mine_t4_done", 32'(done), 32'd1);
    chk("mine_t4_hit", 32'(mine_hit), 32'd1);
    cyc(2);

    // Flag toggling on cell 1
    move(R, "right_c1", 3'd1, 3'd0);
    preload(5'd1, 32'h0000_001A);
    press(F);
    tick_start();
    cyc(2);
    chk("flag_t3_wen", 32'(ram_wen), 32'd1);
    chk("flag_t3_din", ram_din, 32'h0000_001B);
    cyc(1);
    chk("flag_t4_done", 32'(done), 32'd1);
    cyc(2);
    press(S);
    tick_start();
    cyc(1);
    chk("selflag_t2_wen", 32'(ram_wen), 32'd0);
    cyc(1);
    chk("selflag_t3_wen", 32'(ram_wen), 32'd0);
    chk("selflag_t3_done", 32'(done), 32'd1);
    cyc(2);
    press(F);
    tick_start();
    cyc(2);
    chk("unflag_t3_wen", 32'(ram_wen), 32'd1);
    chk("unflag_t3_din", ram_din, 32'h0000_001A);
    cyc(3);

    // Select and flag pending together: reveal first, flag on the next tick
    press(S | F);
    tick_start();
    cyc(2);
    chk("both_t3_din", ram_din, 32'h0000_0011);
    chk("both_t3_wen", 32'(ram_wen), 32'd1);
    cyc(3);
    tick_start();
    chk("both2_busy", 32'(busy), 32'd1);
    cyc(2);
    chk("both2_t3_done", 32'(done), 32'd1);
    chk("both2_t3_wen", 32'(ram_wen), 32'd0);
    cyc(2);

    // Reset in the middle of a reveal
    preload(5'd1, 32'h0000_001A);
    press(S);
    tick_start();
    cyc(1);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_wen", 32'(ram_wen), 32'd0);
    cyc(1);
    chk("mid_rst_wen2", 32'(ram_wen), 32'd0);
    cyc(1);
    reset = 1'b1;
    cyc(3);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_cx", 32'(cursor_x), 32'd0);
    chk("post_rst_cy", 32'(cursor_y), 32'd0);
    chk("post_rst_cell1", mem[1], 32'h0000_001A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/board_access_ctrl.md
Name: board_access_ctrl

Overview:
- Owns the Minesweeper board RAM: 25 cells of 32 bits, one cell per 64x64 tile in the 5x5 grid.
- Shares the single RAM port between the VGA pixel read path and the game's cell updates.
- Moves the highlight cursor from button edges and runs reveal/flag read-modify-write (RMW) sequences only inside vertical blanking.
- Sits between the VGA controller, the button inputs and the board RAM.

Parameters:
GRID_W, 5, grid columns
GRID_H, 5, grid rows
ADDR_W, 10, board RAM address width
DATA_W, 32, board RAM word width

Ports:
clk  in  1  100 MHz system clock
reset  in  1  asynchronous, active-low reset
screen_end  in  1  high between frames (blanking); rising edge = frame tick
left, right, up, down  in  1 each  raw button levels
select  in  1  raw reveal button level
flag  in  1  raw flag button level
vga_addr  in  ADDR_W  cell address requested by the VGA path
vga_data  out  DATA_W  RAM word returned to the VGA path
ram_addr  out  ADDR_W  board RAM address
ram_wen  out  1  board RAM write enable
ram_din  out  DATA_W  board RAM write data
ram_dout  in  DATA_W  board RAM read data (synchronous, 1-cycle latency)
cursor_x  out  3  cursor column, 0..GRID_W-1
cursor_y  out  3  cursor row, 0..GRID_H-1
busy  out  1  high when state is not IDLE
done  out  1  one-cycle pulse when an operation finishes
mine_hit  out  1  one-cycle pulse with done when a mine is revealed

Behaviour:
- Word format: [3:0] display status; [7:4] true contents (0-8 = neighbour count, 9 = mine). Status 10 = covered, 11 = flagged, 0-9 = revealed. Bits [31:8] are written back unchanged.
- Reset (reset=0, async): cursor 0,0; state IDLE; ram_wen 0 immediately; busy, done, mine_hit 0; all pending flags and edge registers cleared. An in-flight operation is abandoned with no write.
- Edge detect: each button is registered once per clk. A rising edge sets that button's pending flag, including while busy. A held button gives exactly one edge.
- Frame tick = screen_end & ~screen_end_q. Everything below happens on the tick cycle T.
- Moves:
  - All pending moves are applied once, then cleared.
  - x: +1 if right, -1 if left; left+right together leave x unchanged. y: same rule with down/up.
  - Clamp to 0..GRID_W-1 and 0..GRID_H-1. No wrap-around.
- Op start (only if state is IDLE):
  - If sel_pend: start a REVEAL and clear sel_pend.
  - Else if flag_pend: start a FLAG and clear flag_pend.
  - If both are pending, select wins; flag_pend is kept for the next tick.
  - A tick while busy starts nothing; pending flags are kept.
- Target cell = cursor_y*GRID_W + cursor_x, using the cursor value before this tick's move; it is latched at T.
- FSM:
  - IDLE -> RD at T.
  - RD (T+1): ram_addr=target, ram_wen=0.
  - CAP (T+2): capture ram_dout into word.
  - Decide step (end of T+2), REVEAL: status==10 -> WR with status := contents. Otherwise -> DONE with no write.
  - Decide step (end of T+2), FLAG: status 10 -> WR with 11; status 11 -> WR with 10; otherwise -> DONE.
  - WR (T+3): ram_addr=target, ram_wen=1, ram_din=modified word.
  - DONE (T+4, or T+3 when there is no write): done=1; mine_hit=1 if a REVEAL wrote contents 9. Then -> IDLE.
- Arbitration:
  - In IDLE: ram_addr=vga_addr, ram_wen=0, vga_data=ram_dout (pass-through).
  - Otherwise: the RAM is owned by the FSM and vga_data holds its last IDLE value.
- ram_wen is asserted only in WR.

Test Plan:
- Reset released, idle -> cursor 0,0; ram_wen 0; vga_addr=7 reaches ram_addr and vga_data tracks ram_dout.
- Press right 6 times (one per frame), then down 1 -> cursor_x stops at 4, cursor_y=1; left+right in the same frame -> x unchanged.
- Cursor (2,1), cell 7 holds 0x0000_003A, select then tick -> RD at T+1, ram_wen=1 at T+3 with ram_din=0x0000_0033, done at T+4, mine_hit=0.
- Cell 0 holds 0x0000_009A, reveal -> writes 0x0000_0099; done and mine_hit both pulse together.
- Flag on 0x..1A -> writes 0x..1B; select on 0x..1B -> no write, done at T+3; flag again -> writes 0x..1A.
- reset low at T+2 of a reveal -> ram_wen never rises, busy falls immediately; after release, state IDLE and cursor 0,0.
